// File: rtl/main_control.sv
// main_control: multicycle MIPS main control FSM.
// Sequences each instruction through fetch, decode, execute, memory and
// write-back, and decodes the current state into datapath enables.
// The memory states wait for mem_ready.
// Define MAIN_CONTROL_ADDI_EN to add addi support (ADDI_EXEC/ADDI_WB states).
// Without it, opcode 001000 is treated as illegal.
// Outputs are a pure decode of the state register, plus mem_ready in FETCH
// and opcode in DECODE. As a result, reset shows FETCH values immediately.
module main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state_out
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
`ifdef MAIN_CONTROL_ADDI_EN
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
`else
    S_JUMP      = 4'd9
`endif
  } state_t;

  state_t state;

  logic op_legal;

  // Opcodes the decode stage knows how to dispatch.
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
`ifdef MAIN_CONTROL_ADDI_EN
      OP_ADDI:                              op_legal = 1'b1;
`endif
      default:                              op_legal = 1'b0;
    endcase
  end

  // State register and next-state sequencing. Unused codes fall back to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:     if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:      state <= S_EXECUTE;
            OP_LW, OP_SW:  state <= S_MEM_ADDR;
            OP_BEQ:        state <= S_BRANCH;
            OP_J:          state <= S_JUMP;
`ifdef MAIN_CONTROL_ADDI_EN
            OP_ADDI:       state <= S_ADDI_EXEC;
`endif
            default:       state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: begin
          if (opcode == OP_LW)      state <= S_MEM_READ;
          else if (opcode == OP_SW) state <= S_MEM_WRITE;
          else                      state <= S_FETCH;
        end
        S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
        S_MEM_WB:    state <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
        S_EXECUTE:   state <= S_R_WB;
        S_R_WB:      state <= S_FETCH;
        S_BRANCH:    state <= S_FETCH;
        S_JUMP:      state <= S_FETCH;
`ifdef MAIN_CONTROL_ADDI_EN
        S_ADDI_EXEC: state <= S_ADDI_WB;
        S_ADDI_WB:   state <= S_FETCH;
`endif
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Datapath enables decoded from the current state; everything defaults to 0.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~op_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
`ifdef MAIN_CONTROL_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  assign state_out = state;

endmodule

// File: tb/tb_main_control.sv
// tb_main_control: random instruction streams for main_control.
// The driver expands each instruction into its per-cycle control words,
// taken straight from the state table, and queues them. A negedge monitor
// compares every queued word against the DUT outputs.
module tb_main_control;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       m2r;
    logic       rdst;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [1:0] aop;
    logic       ill;
  } ctl_t;

  localparam int W = $bits(ctl_t);

  // clock/reset block
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state_out;

  main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .illegal_op(illegal_op), .state_out(state_out)
  );

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // reference control words
  function automatic ctl_t w_zero(input logic [3:0] st);
    ctl_t c;
    c = '0;
    c.st = st;
    return c;
  endfunction

  function automatic ctl_t w_fetch(input logic rdy);
    ctl_t c;
    c = w_zero(4'd0);
    c.mr = 1'b1; c.asb = 2'b01; c.pcw = rdy; c.irw = rdy;
    return c;
  endfunction

  function automatic ctl_t w_decode(input logic ill);
    ctl_t c;
    c = w_zero(4'd1);
    c.asb = 2'b11; c.ill = ill;
    return c;
  endfunction

  function automatic ctl_t w_mem_addr();
    ctl_t c;
    c = w_zero(4'd2);
    c.asa = 1'b1; c.asb = 2'b10;
    return c;
  endfunction

  function automatic ctl_t w_mem_read();
    ctl_t c;
    c = w_zero(4'd3);
    c.mr = 1'b1; c.iord = 1'b1;
    return c;
  endfunction

  function automatic ctl_t w_mem_wb();
    ctl_t c;
    c = w_zero(4'd4);
    c.m2r = 1'b1; c.rw = 1'b1;
    return c;
  endfunction

  function automatic ctl_t w_mem_write();
    ctl_t c;
    c = w_zero(4'd5);
    c.mw = 1'b1; c.iord = 1'b1;
    return c;
  endfunction

  function automatic ctl_t w_execute();
    ctl_t c;
    c = w_zero(4'd6);
    c.asa = 1'b1; c.aop = 2'b10;
    return c;
  endfunction

  function automatic ctl_t w_r_wb();
    ctl_t c;
    c = w_zero(4'd7);
    c.rdst = 1'b1; c.rw = 1'b1;
    return c;
  endfunction

  function automatic ctl_t w_branch();
    ctl_t c;
    c = w_zero(4'd8);
    c.asa = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.pcs = 2'b01;
    return c;
  endfunction

  function automatic ctl_t w_jump();
    ctl_t c;
    c = w_zero(4'd9);
    c.pcw = 1'b1; c.pcs = 2'b10;
    return c;
  endfunction

  function automatic ctl_t w_addi_exec();
    ctl_t c;
    c = w_zero(4'd10);
    c.asa = 1'b1; c.asb = 2'b10;
    return c;
  endfunction

  function automatic ctl_t w_addi_wb();
    ctl_t c;
    c = w_zero(4'd11);
    c.rw = 1'b1;
    return c;
  endfunction

`ifdef MAIN_CONTROL_ADDI_EN
  localparam bit ADDI_ON = 1'b1;
`else
  localparam bit ADDI_ON = 1'b0;
`endif

  // driver tasks: one call = one clock cycle, entered just after a rising edge
  task automatic cyc(input logic rdy, input logic [5:0] op, input ctl_t e);
    mem_ready = rdy;
    opcode = op;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] junk();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction: fw wait cycles in FETCH, mw wait cycles in the memory
  // state (if any). Opcode is valid only where the control unit looks at it.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit legal;
    for (int i = 0; i < fw; i++) cyc(1'b0, junk(), w_fetch(1'b0));
    cyc(1'b1, junk(), w_fetch(1'b1));
    legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
            (op == 6'b000100) || (op == 6'b000010) ||
            (op == 6'b001000 && ADDI_ON);
    cyc(rnd_bit(), op, w_decode(!legal));
    if (legal) begin
      case (op)
        6'b000000: begin
          cyc(rnd_bit(), junk(), w_execute());
          cyc(rnd_bit(), junk(), w_r_wb());
        end
        6'b100011: begin
          cyc(rnd_bit(), op, w_mem_addr());
          for (int i = 0; i < mw; i++) cyc(1'b0, junk(), w_mem_read());
          cyc(1'b1, junk(), w_mem_read());
          cyc(rnd_bit(), junk(), w_mem_wb());
        end
        6'b101011: begin
          cyc(rnd_bit(), op, w_mem_addr());
          for (int i = 0; i < mw; i++) cyc(1'b0, junk(), w_mem_write());
          cyc(1'b1, junk(), w_mem_write());
        end
        6'b000100: cyc(rnd_bit(), junk(), w_branch());
        6'b000010: cyc(rnd_bit(), junk(), w_jump());
        default: begin
          cyc(rnd_bit(), junk(), w_addi_exec());
          cyc(rnd_bit(), junk(), w_addi_wb());
        end
      endcase
    end
  endtask

  // scoreboard monitor: compare away from the rising edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t e;
      ctl_t a;
      e = exp_q.pop_front();
      a.st = state_out; a.pcw = pc_write; a.pcwc = pc_write_cond;
      a.pcs = pc_source; a.iord = i_or_d; a.mr = mem_read; a.mw = mem_write;
      a.irw = ir_write; a.m2r = mem_to_reg; a.rdst = reg_dst;
      a.rw = reg_write; a.asa = alu_src_a; a.asb = alu_src_b; a.aop = alu_op;
      a.ill = illegal_op;
      total = total + 1;
      if (a !== e) begin
        bad = bad + 1;
        $display("FAIL ctl_word t=%0t: got state=%0d word=%h, expected state=%0d word=%h",
                 $time, a.st, a, e.st, e);
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
    $fatal(1);
  end

  logic [5:0] ops [0:5];

  initial begin
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;

    // reset state: FETCH values with pc_write/ir_write following mem_ready
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b0, junk(), w_fetch(1'b0));
    cyc(1'b1, junk(), w_fetch(1'b1));
    reset = 1'b0;

    // directed instructions
    run_instr(6'b100011, 0, 0);   // lw, 5 cycles
    run_instr(6'b000000, 0, 0);   // R-type, 4 cycles
    run_instr(6'b101011, 2, 3);   // sw: fetch waits 2, mem_write held 4 cycles
    run_instr(6'b000100, 0, 0);   // beq
    run_instr(6'b000010, 0, 0);   // j
    run_instr(6'b001000, 0, 0);   // addi (legal only when configured in)
    run_instr(6'b111111, 1, 0);   // illegal

    // reset pulse in the middle of a stalled MEM_WRITE
    cyc(1'b1, junk(), w_fetch(1'b1));
    cyc(1'b0, 6'b101011, w_decode(1'b0));
    cyc(1'b0, 6'b101011, w_mem_addr());
    cyc(1'b0, junk(), w_mem_write());
    reset = 1'b1;
    #1;
    total = total + 1;
    if (state_out !== 4'd0) begin
      bad = bad + 1;
      $display("FAIL reset_state t=%0t: got state=%0d, expected 0", $time, state_out);
    end
    total = total + 1;
    if (mem_write !== 1'b0) begin
      bad = bad + 1;
      $display("FAIL reset_mem_write t=%0t: got %b, expected 0", $time, mem_write);
    end
    cyc(1'b0, junk(), w_fetch(1'b0));
    cyc(1'b1, junk(), w_fetch(1'b1));
    reset = 1'b0;
    run_instr(6'b100011, 0, 1);

    // random instruction stream
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = junk();
      else op = ops[$urandom_range(0, 5)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // drain the queue, then report
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: %0d expected words never compared, expected 0", exp_q.size());
    end
    if (total < 100) begin
      bad = bad + 1;
      $display("FAIL coverage: only %0d words compared, expected at least 100", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else $display("FAIL: %0d mismatches", bad);
    $finish;
  end

endmodule
